// File: rtl/clk_freq_checker.sv
// Counts rising edges of an asynchronous signal over a fixed window of clk cycles,
// reports each window's count, checks it against a tolerance band and tracks lock.
module clk_freq_checker #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16,
    parameter int EXP_COUNT   = 256,
    parameter int TOL         = 2,
    parameter int LOCK_N      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             locked
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [GATE_W-1:0]       GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
    localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W + 1)'(EXP_COUNT);
    localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W + 1)'(TOL);
    localparam logic [GOOD_W-1:0]       LOCK_LAST = GOOD_W'(LOCK_N);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state_reg, state_next;

    logic              sync1_reg, sync2_reg, dly_reg;
    logic [GATE_W-1:0] gate_reg;
    logic [CNT_W-1:0]  edge_cnt_reg;
    logic              ovf_reg;
    logic [GOOD_W-1:0] good_reg;

    logic              edge_det;
    logic              win_end;
    logic              abort;
    logic              cnt_at_max;
    logic [CNT_W-1:0]  cnt_final;
    logic              ovf_final;
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] abs_diff;
    logic              win_good;
    logic [GOOD_W-1:0] good_inc;

    assign edge_det = sync2_reg & ~dly_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // en=0 takes priority over a window end in the same cycle: the window is dropped.
    always_comb begin
        state_next = state_reg;
        win_end    = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (gate_reg == GATE_LAST) begin
                    win_end = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Final window values include a detect pulse arriving in the last gate cycle.
    always_comb begin
        cnt_at_max = (edge_cnt_reg == CNT_MAX);
        cnt_final  = (edge_det && !cnt_at_max) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
        ovf_final  = ovf_reg | (edge_det & cnt_at_max);
        diff       = $signed({1'b0, cnt_final}) - EXP_S;
        abs_diff   = diff[CNT_W] ? -diff : diff;
        win_good   = !ovf_final && (abs_diff <= TOL_S);
        good_inc   = (good_reg == LOCK_LAST) ? LOCK_LAST : good_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            dly_reg      <= 1'b0;
            gate_reg     <= '0;
            edge_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            good_reg     <= '0;
            meas_count   <= '0;
            meas_valid   <= 1'b0;
            in_range     <= 1'b0;
            overflow     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sync1_reg  <= sig_in;
            sync2_reg  <= sync1_reg;
            dly_reg    <= sync2_reg;
            meas_valid <= 1'b0;
            if (abort) begin
                gate_reg     <= '0;
                edge_cnt_reg <= '0;
                ovf_reg      <= 1'b0;
                good_reg     <= '0;
                locked       <= 1'b0;
            end else if (win_end) begin
                meas_count   <= cnt_final;
                meas_valid   <= 1'b1;
                overflow     <= ovf_final;
                in_range     <= win_good;
                gate_reg     <= '0;
                edge_cnt_reg <= '0;
                ovf_reg      <= 1'b0;
                if (win_good) begin
                    good_reg <= good_inc;
                    locked   <= (good_inc == LOCK_LAST);
                end else begin
                    good_reg <= '0;
                    locked   <= 1'b0;
                end
            end else if (state_reg == MEASURE) begin
                gate_reg <= gate_reg + 1'b1;
                if (edge_det && !cnt_at_max) begin
                    edge_cnt_reg <= edge_cnt_reg + 1'b1;
                end
                if (edge_det && cnt_at_max) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

endmodule
